rr_sel: RTL



---
 rtl/rr_sel.sv | 97 +++++++++
 1 files changed

// File: rtl/rr_sel.sv
// rr_sel: round-robin grant sequencer that drives the enable and select inputs of a 3-to-8 decoder.
// Each grant is limited to HOLD cycles, and there is always one idle cycle between two grants.
// Optional build macro RR_SEL_PRIO_EN: switches to fixed priority, where the lowest index wins
// and the rotation pointer stays at 0.
module rr_sel #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rel,
  output logic       e,
  output logic [2:0] i
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            e_q;
  logic [IW-1:0]   i_q;

  logic [IW-1:0]   winner_c;
  logic            found_c;
  logic [IW-1:0]   idx_c;
  logic            end_c;

  // Find the first requester, scanning upward from ptr and wrapping past 7.
  // In fixed-priority mode ptr is always 0, so this scan returns the lowest set index.
  always_comb begin
    winner_c = ptr_q;
    found_c  = 1'b0;
    idx_c    = '0;
    for (int k = 0; k < N; k++) begin
      idx_c = ptr_q + IW'(k);
      if (!found_c && req[idx_c]) begin
        winner_c = idx_c;
        found_c  = 1'b1;
      end
    end
  end

  // The grant ends on a release pulse, on a withdrawn request, or when the hold limit is reached.
  // Any combination of these counts as a single end.
  assign end_c = rel | ~req[i_q] | (cnt_q == CW'(HOLD));

  // Arbitration FSM. All outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      i_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            i_q     <= winner_c;
            e_q     <= 1'b1;
            cnt_q   <= CW'(1);
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (end_c) begin
            e_q     <= 1'b0;
            state_q <= IDLE;
`ifdef RR_SEL_PRIO_EN
            ptr_q   <= '0;
`else
            ptr_q   <= i_q + IW'(1);
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          e_q     <= 1'b0;
        end
      endcase
    end
  end

  assign e = e_q;
  assign i = i_q;

endmodule
